// File: rtl/proc_pkg.sv
// Shared definitions for the 12-bit ADD/SUB processor: instruction field
// positions, opcode encodings and the sequencer state type.
package proc_pkg;

  localparam int unsigned INSTR_W = 12;

  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned OPC_BIT = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StDecode,
    StExecute,
    StWriteback
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer: fetches run_len instructions from
// start_pc and steers register-file addresses, write enable and ALU op.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned RA_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic [PC_W-1:0]    run_len,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic [RA_W-1:0]    rf_raddr_a,
  output logic [RA_W-1:0]    rf_raddr_b,
  output logic [RA_W-1:0]    rf_waddr,
  output logic               rf_we,
  output logic               alu_op,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done
);

  seq_state_e         state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [PC_W-1:0]    remaining_q;
  logic               halt_q;
  logic [PC_W-1:0]    remaining_dec;
  logic               last_instr;
  logic               ir_live;
  logic               unused_ir;

  assign remaining_dec = remaining_q - PC_W'(1);
  // A halt arriving in the writeback cycle itself still ends the run here.
  assign last_instr    = (remaining_dec == '0) || halt_q || halt;
  assign ir_live       = state_q inside {StDecode, StExecute, StWriteback};

  assign imem_addr  = pc;
  assign busy       = (state_q != StIdle);
  assign rf_raddr_a = ir_live ? RA_W'(ir_q[RS1_MSB:RS1_LSB]) : '0;
  assign rf_raddr_b = ir_live ? RA_W'(ir_q[RS2_MSB:RS2_LSB]) : '0;
  assign rf_waddr   = ir_live ? RA_W'(ir_q[RD_MSB:RD_LSB])   : '0;
  assign alu_op     = ir_live ? ir_q[OPC_BIT] : OP_ADD;

  // Reserved instruction bits carry no meaning.
  assign unused_ir = ^ir_q[2:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ir_q        <= '0;
      remaining_q <= '0;
      halt_q      <= 1'b0;
      pc          <= '0;
      imem_req    <= 1'b0;
      rf_we       <= 1'b0;
      done        <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      rf_we    <= 1'b0;
      done     <= 1'b0;
      if (state_q != StIdle && halt) begin
        halt_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pc          <= start_pc;
            remaining_q <= run_len;
            halt_q      <= 1'b0;
            if (run_len == '0) begin
              done <= 1'b1;
            end else begin
              state_q  <= StFetch;
              imem_req <= 1'b1;
            end
          end
        end
        StFetch: begin
          state_q <= StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            ir_q    <= imem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          state_q <= StExecute;
        end
        StExecute: begin
          state_q <= StWriteback;
          rf_we   <= 1'b1;
        end
        StWriteback: begin
          pc          <= pc + PC_W'(1);
          remaining_q <= remaining_dec;
          if (last_instr) begin
            state_q <= StIdle;
            done    <= 1'b1;
          end else begin
            state_q  <= StFetch;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
